// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared types for the memory-stage load/store unit.
//   RamAddress / Word : byte-address and data-word types
//   LsuState          : IDLE / MERGE sequencer states
//   MemFunct3         : RV32I load/store width encodings
//   word_address()    : clears the byte-offset bits of an address
package mem_lsu_pkg;

  localparam int RAM_ADDR_W = 16;
  localparam int DATA_W     = 32;

  typedef logic [RAM_ADDR_W-1:0] RamAddress;
  typedef logic [DATA_W-1:0]     Word;

  typedef enum logic {
    LSU_IDLE  = 1'b0,
    LSU_MERGE = 1'b1
  } LsuState;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } MemFunct3;

  function automatic RamAddress word_address(input RamAddress addr);
    return {addr[RAM_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/lsu_extract.sv
// lsu_extract: selects the addressed byte/halfword of a RAM word and
// sign- or zero-extends it according to funct3.
//   funct3 : RV32I load width code
//   offset : byte offset within the word (address bits [1:0])
//   word   : RAM read word
//   data   : extended load result (0 for unused codes)
module lsu_extract
  import mem_lsu_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [1:0] offset,
  input  Word        word,
  output Word        data
);

  logic signed [7:0]  byte_sel;
  logic signed [15:0] half_sel;

  always_comb begin
    case (offset)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    // offset[0] is ignored for halfwords so unchecked accesses use the
    // naturally aligned halfword
    half_sel = offset[1] ? word[31:16] : word[15:0];

    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'd0, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'd0, half_sel};
      F3_W:    data = word;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: memory-stage load/store unit in front of a single-port RAM with
// combinational read. Loads and word stores complete in the request cycle;
// byte/halfword stores read-modify-write over two cycles (one stall).
//   clk, reset (async, active-low)
//   req_valid/req_write/req_funct3/req_address/req_data : access request
//   load_data    : extended load result
//   stall        : hold the memory stage (request must stay stable)
//   misaligned   : current request is misaligned (CHECK_ALIGN=1 only)
//   error_sticky : set by any misaligned request, cleared by reset
//   ram_write_enable/ram_address/ram_in/ram_out : RAM port
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter bit CHECK_ALIGN = 1'b1
)(
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic       req_write,
  input  logic [2:0] req_funct3,
  input  RamAddress  req_address,
  input  Word        req_data,
  output Word        load_data,
  output logic       stall,
  output logic       misaligned,
  output logic       error_sticky,
  output logic       ram_write_enable,
  output RamAddress  ram_address,
  output Word        ram_in,
  input  Word        ram_out
);

  LsuState   state;
  RamAddress merge_addr;
  Word       merge_word;
  Word       extracted;
  Word       merged;

  logic is_b, is_h, is_w, is_bu, is_hu;
  logic op_ok, addr_bad, idle_req, bad_req, go;

  assign is_b  = (req_funct3 == F3_B);
  assign is_h  = (req_funct3 == F3_H);
  assign is_w  = (req_funct3 == F3_W);
  assign is_bu = (req_funct3 == F3_BU);
  assign is_hu = (req_funct3 == F3_HU);

  // Stores only have B/H/W; any other code is a silent no-op
  assign op_ok    = req_write ? (is_b | is_h | is_w)
                              : (is_b | is_h | is_w | is_bu | is_hu);
  assign addr_bad = ((is_h | is_hu) & req_address[0]) |
                    (is_w & (req_address[1:0] != 2'b00));

  // A request is only decoded in IDLE; in MERGE it is the held copy
  assign idle_req = req_valid & (state == LSU_IDLE);
  assign bad_req  = idle_req & op_ok & addr_bad & CHECK_ALIGN;
  assign go       = idle_req & op_ok & ~bad_req;

  assign misaligned       = bad_req;
  assign stall            = reset & go & req_write & ~is_w;
  assign ram_write_enable = reset & ((state == LSU_MERGE) | (go & req_write & is_w));
  assign ram_address      = (state == LSU_MERGE) ? merge_addr : word_address(req_address);
  assign ram_in           = (state == LSU_MERGE) ? merge_word : req_data;
  assign load_data        = (go & ~req_write) ? extracted : '0;

  lsu_extract u_extract (
    .funct3 (req_funct3),
    .offset (req_address[1:0]),
    .word   (ram_out),
    .data   (extracted)
  );

  // Replace the target lane of the current RAM word with the store data
  always_comb begin
    merged = ram_out;
    if (is_b) begin
      case (req_address[1:0])
        2'd0:    merged[7:0]   = req_data[7:0];
        2'd1:    merged[15:8]  = req_data[7:0];
        2'd2:    merged[23:16] = req_data[7:0];
        default: merged[31:24] = req_data[7:0];
      endcase
    end else if (req_address[1]) begin
      merged[31:16] = req_data[15:0];
    end else begin
      merged[15:0] = req_data[15:0];
    end
  end

  // Sequencer and merge registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= LSU_IDLE;
      merge_addr   <= '0;
      merge_word   <= '0;
      error_sticky <= 1'b0;
    end else begin
      if (bad_req)
        error_sticky <= 1'b1;
      case (state)
        LSU_IDLE: begin
          if (stall) begin
            state      <= LSU_MERGE;
            merge_addr <= word_address(req_address);
            merge_word <= merged;
          end
        end
        default: state <= LSU_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter CHECK_ALIGN, default 1: when 1, misaligned accesses are flagged and suppressed; when 0, low address bits below access size are ignored.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  memory-stage access present this cycle.
REQ-005 req_write  input  1  1 = store, 0 = load.
REQ-006 req_funct3  input  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 req_address  input  RamAddress  byte address.
REQ-008 req_data  input  Word  store data; low byte/halfword used for B/H.
REQ-009 load_data  output  Word  extended load result.
REQ-010 stall  output  1  hold the memory stage; request must be held stable.
REQ-011 misaligned  output  1  current request is misaligned (combinational).
REQ-012 error_sticky  output  1  set by any misaligned request; cleared only by reset.
REQ-013 ram_write_enable  output  1  RAM write port enable.
REQ-014 ram_address  output  RamAddress  word-aligned RAM address (bits [1:0] = 0).
REQ-015 ram_in  output  Word  RAM write data.
REQ-016 ram_out  input  Word  RAM combinational read data for ram_address.

Function
REQ-017 Two-state FSM, IDLE and MERGE; only sub-word stores leave IDLE.
REQ-018 IDLE, load: ram_address = aligned req_address; load_data combinationally selects byte addr[1:0] / halfword addr[1]; B/H sign-extend, BU/HU zero-extend, W passes through; stall = 0; zero-cycle latency.
REQ-019 IDLE, word store: ram_write_enable = 1, ram_in = req_data, stall = 0, same cycle.
REQ-020 IDLE, B/H store: ram_write_enable = 0, stall = 1; at posedge register aligned address and merged word (ram_out with target byte/halfword replaced by req_data low bits); go to MERGE.
REQ-021 MERGE: ram_write_enable = 1, ram_address and ram_in from registers, stall = 0; return to IDLE at next posedge; request still on inputs this cycle is not re-decoded.
REQ-022 Sub-word store total latency: 2 cycles, exactly one stall cycle.
REQ-023 Misaligned: H with addr[0]=1, W with addr[1:0]!=0. With CHECK_ALIGN=1: misaligned = 1, no RAM write, load_data = 0, stall = 0, FSM stays IDLE, error_sticky set at posedge. With CHECK_ALIGN=0: misaligned = 0, access proceeds at the naturally aligned address.
REQ-024 req_valid = 0 in IDLE: ram_write_enable = 0, stall = 0, load_data = 0, misaligned = 0.
REQ-025 Unused funct3 codes (011, 110, 111) are treated as no-op: no write, load_data = 0, no error.
REQ-026 ram_write_enable is never asserted for more than one cycle per request.

Reset
REQ-027 reset low: FSM -> IDLE, merge registers -> 0, error_sticky -> 0, immediately, regardless of clk.
REQ-028 Reset asserted in MERGE aborts the pending write: ram_write_enable = 0 while reset is low and after release.
REQ-029 While reset is low: stall = 0, ram_write_enable = 0.

Structure
REQ-030 LsuState enum and MemFunct3 encodings live in types.svh; address alignment uses the existing WORD_ADDRESS helper in utils.svh.
REQ-031 One sub-module, lsu_extract (combinational byte/halfword select plus extension), is instantiated for load_data.
REQ-032 Single always_ff for FSM/registers; all outputs otherwise combinational.

Verification
REQ-033 Word store 0xDEADBEEF to 0x10, then LW 0x10 -> load_data = 0xDEADBEEF, no stall cycles.
REQ-034 SB 0x80 to 0x11 over word 0x11223344 -> stall one cycle, then RAM word 0x11228044; LB 0x11 -> 0xFFFFFF80, LBU 0x11 -> 0x00000080.
REQ-035 SH 0xABCD to 0x12 over 0x00000000 -> RAM 0xABCD0000; LH 0x12 -> 0xFFFFABCD.
REQ-036 LW 0x13 with CHECK_ALIGN=1 -> misaligned = 1, load_data = 0, error_sticky = 1 next cycle, no RAM write.
REQ-037 Reset low during MERGE of SB 0x55 to 0x20 -> FSM IDLE, RAM word at 0x20 unchanged, error_sticky = 0.
REQ-038 Back-to-back SB 0x01 to 0x30, SB 0x02 to 0x31 -> 4 cycles total, RAM word 0x30 low half = 0x0201.
